beta_mem_arbiter: RTL and testbench
===================================

// Module: beta_mem_arbiter
// PURPOSE
//  Shares one single-ported memory between the Beta core's instruction-fetch port and
//  data port. Sits between Beta_core and memory; arbitrates, registers the winning
//  request, waits for memory ack, returns read data and a one-cycle ready pulse to the winner.
//  Data wins by default (older instruction); a streak limit prevents fetch starvation.
// PARAMETERS
//  ADDR_W           32  address width
//  DATA_W           32  data width
//  MAX_DATA_STREAK  4   back-to-back data grants allowed while fetch waits (>=1)
//  TIMEOUT_CYCLES   64  wait-for-ack limit (used only with BETA_ARB_TIMEOUT_EN)
// PORTS
//  clk                 in   1       clock, all logic on posedge
//  rst                 in   1       synchronous reset, active-low (0 = reset)
//  InstructionAddress  in   ADDR_W  fetch address
//  iReq                in   1       fetch request; held until instructionReady
//  InstructionData     out  DATA_W  fetch data, valid while instructionReady=1
//  instructionReady    out  1       one-cycle fetch completion pulse
//  DataAddress         in   ADDR_W  data address
//  DataWrite           in   DATA_W  store data
//  WriteEnable         in   1       store request; held until dataReady
//  ReadEnable          in   1       load request; held until dataReady
//  DataRead            out  DATA_W  load data, valid while dataReady=1
//  dataReady           out  1       one-cycle data completion pulse
//  memAddress          out  ADDR_W  memory address
//  memWData            out  DATA_W  memory write data
//  memWE / memRE       out  1       memory write / read strobes
//  memRData            in   DATA_W  memory read data, valid with memAck
//  memAck              in   1       memory completion
//  busErr              out  1       only with BETA_ARB_TIMEOUT_EN: timeout flag, with ready pulse
// BEHAVIOUR
//  States: IDLE -> GRANT_I | GRANT_D -> RESP -> IDLE.
//  Reset (rst=0 at edge): state IDLE, all outputs 0, streak=0; mid-access the transaction
//   is dropped, no ready pulse, strobes fall the cycle after reset is sampled.
//  dReq = ReadEnable|WriteEnable. IDLE picks: dReq & !(iReq & streak==MAX_DATA_STREAK) ->
//   GRANT_D; else iReq -> GRANT_I; else stay. Address/data/op latched on that edge.
//  streak: +1 per data grant while iReq=1 (saturates); cleared on any fetch grant or when
//   a data grant happens with iReq=0.
//  GRANT_x: memAddress/memWData/memWE/memRE driven from latched regs (registered outputs);
//   WriteEnable&ReadEnable both set -> write only (memWE=1, memRE=0). Fetch always memRE=1.
//  memAck in GRANT_x: capture memRData, strobes drop, -> RESP. memAck outside GRANT ignored.
//  RESP: exactly one of instructionReady/dataReady =1 for one cycle with captured data;
//   requests ignored this cycle; -> IDLE. Min 3 cycles/access with 1-cycle memory.
//  Output data buses hold last captured value when ready=0 (store: DataRead holds prior).
//  Request dropped during GRANT_x: access still completes, ready still pulses.
//  Grant address changes while granted are ignored (latched copy used).
// CONFIGURATION
//  BETA_ARB_TIMEOUT_EN defined: counter in GRANT_x; TIMEOUT_CYCLES cycles without memAck ->
//   strobes drop, RESP with ready pulse, busErr=1 same cycle, data = 0. busErr reset 0.
//  Undefined: no busErr port, no counter; GRANT_x waits indefinitely for memAck.
// STRUCTURE
//  Shared package beta_mem_pkg: state encodings (IDLE/GRANT_I/GRANT_D/RESP), grant-owner
//   codes, default widths; also used by the future cache controller.
//  One sub-module: beta_arb_watchdog (load/clear/expire counter), instantiated only under
//   BETA_ARB_TIMEOUT_EN. Arbitration and FSM stay in this module.
// TESTING
//  1. rst=0 2 cycles, then iReq=1 addr 0x100, memAck 1 cycle later, memRData=0xDEADBEEF ->
//     memRE=1/addr 0x100; instructionReady 1 cycle, InstructionData=0xDEADBEEF.
//  2. iReq & ReadEnable same cycle, addr 0x40 / 0x200 -> data granted first (memAddress 0x200),
//     dataReady pulse, then fetch of 0x40.
//  3. dReq held continuously, iReq held, MAX_DATA_STREAK=4 -> exactly 4 data grants, then
//     1 fetch grant, streak reset, pattern repeats.
//  4. WriteEnable=ReadEnable=1, DataWrite=0x12345678 addr 0x80 -> memWE=1, memRE=0,
//     memWData=0x12345678; dataReady pulse; DataRead unchanged.
//  5. rst=0 in GRANT_D before memAck -> strobes 0 next cycle, no dataReady, later memAck ignored.
//  6. BETA_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8, no memAck -> after 8 cycles ready + busErr=1,
//     data 0; next request serviced normally with busErr=0.

Source files
------------

// File: rtl/beta_mem_pkg.sv
// Shared definitions for the Beta memory path: arbiter state encodings,
// grant-owner codes and default bus widths. Also used by the cache controller.
package beta_mem_pkg;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_I = 2'd1,
        GRANT_D = 2'd2,
        RESP    = 2'd3
    } arb_state_e;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } arb_owner_e;

endpackage

// File: rtl/beta_mem_arbiter_if.sv
// Core-side and memory-side bus of the Beta memory arbiter.
// slave  : the arbiter's view (serves core requests, drives memory).
// master : the environment's view (core plus memory).
// BETA_ARB_TIMEOUT_EN adds the busErr timeout flag.
interface beta_mem_arbiter_if
    import beta_mem_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);
    logic [ADDR_W-1:0] InstructionAddress;
    logic              iReq;
    logic [DATA_W-1:0] InstructionData;
    logic              instructionReady;
    logic [ADDR_W-1:0] DataAddress;
    logic [DATA_W-1:0] DataWrite;
    logic              WriteEnable;
    logic              ReadEnable;
    logic [DATA_W-1:0] DataRead;
    logic              dataReady;
    logic [ADDR_W-1:0] memAddress;
    logic [DATA_W-1:0] memWData;
    logic              memWE;
    logic              memRE;
    logic [DATA_W-1:0] memRData;
    logic              memAck;
`ifdef BETA_ARB_TIMEOUT_EN
    logic              busErr;
`endif

    modport slave (
`ifdef BETA_ARB_TIMEOUT_EN
        output busErr,
`endif
        input  InstructionAddress, iReq, DataAddress, DataWrite,
        input  WriteEnable, ReadEnable, memRData, memAck,
        output InstructionData, instructionReady, DataRead, dataReady,
        output memAddress, memWData, memWE, memRE
    );

    modport master (
`ifdef BETA_ARB_TIMEOUT_EN
        input  busErr,
`endif
        output InstructionAddress, iReq, DataAddress, DataWrite,
        output WriteEnable, ReadEnable, memRData, memAck,
        input  InstructionData, instructionReady, DataRead, dataReady,
        input  memAddress, memWData, memWE, memRE
    );

endinterface

// File: rtl/beta_arb_watchdog.sv
// Wait-for-ack watchdog: counts cycles while the arbiter holds a grant and
// flags expiry on the TIMEOUT_CYCLES-th grant cycle. Cleared whenever not running.
module beta_arb_watchdog #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic i_run,
    output logic o_expire
);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] r_cnt;

    // Count grant cycles; hold at the expiry value, restart when the grant ends.
    always_ff @(posedge clk) begin
        if (!rst || !i_run)
            r_cnt <= '0;
        else if (!o_expire)
            r_cnt <= r_cnt + 1'b1;
    end

    assign o_expire = i_run && (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/beta_mem_arbiter.sv
// Beta memory arbiter: shares one single-ported memory between instruction
// fetch and data access. Data wins by default; after MAX_DATA_STREAK
// back-to-back data grants with a fetch waiting, the fetch is granted.
// BETA_ARB_TIMEOUT_EN adds a wait-for-ack watchdog and the busErr flag.
module beta_mem_arbiter
    import beta_mem_pkg::*;
#(
    parameter int ADDR_W          = DEF_ADDR_W,
    parameter int DATA_W          = DEF_DATA_W,
    parameter int MAX_DATA_STREAK = 4
`ifdef BETA_ARB_TIMEOUT_EN
    , parameter int TIMEOUT_CYCLES = 64
`endif
) (
    input  logic              clk,
    input  logic              rst,
    beta_mem_arbiter_if.slave bus
);
    localparam int STREAK_W = $clog2(MAX_DATA_STREAK + 1);

    arb_state_e        r_state, w_next;
    arb_owner_e        r_owner;
    logic [STREAK_W-1:0] r_streak;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata, r_idata, r_dread;
    logic              r_we, r_re;
    logic              w_dreq, w_streak_full, w_grant_d, w_grant_i, w_done, w_timeout;
    logic [DATA_W-1:0] w_cap;

    assign w_dreq        = bus.ReadEnable || bus.WriteEnable;
    assign w_streak_full = (r_streak == STREAK_W'(MAX_DATA_STREAK));
    // A timed-out access returns zero data.
    assign w_cap         = w_timeout ? '0 : bus.memRData;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    // Arbitration and next-state decode.
    always_comb begin
        w_next    = r_state;
        w_grant_d = 1'b0;
        w_grant_i = 1'b0;
        w_done    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_dreq && !(bus.iReq && w_streak_full)) begin
                    w_grant_d = 1'b1;
                    w_next    = GRANT_D;
                end else if (bus.iReq) begin
                    w_grant_i = 1'b1;
                    w_next    = GRANT_I;
                end
            end
            GRANT_I, GRANT_D: begin
                if (bus.memAck || w_timeout) begin
                    w_done = 1'b1;
                    w_next = RESP;
                end
            end
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Latch the winning request, run the strobes, capture response data.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_owner  <= OWN_I;
            r_streak <= '0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_we     <= 1'b0;
            r_re     <= 1'b0;
            r_idata  <= '0;
            r_dread  <= '0;
        end else begin
            if (w_grant_d) begin
                r_owner <= OWN_D;
                r_addr  <= bus.DataAddress;
                r_wdata <= bus.DataWrite;
                r_we    <= bus.WriteEnable;
                r_re    <= !bus.WriteEnable;     // write wins when both are set
                // A data grant with fetch waiting implies streak < max, so no overflow.
                r_streak <= bus.iReq ? r_streak + 1'b1 : '0;
            end else if (w_grant_i) begin
                r_owner  <= OWN_I;
                r_addr   <= bus.InstructionAddress;
                r_we     <= 1'b0;
                r_re     <= 1'b1;
                r_streak <= '0;
            end
            if (w_done) begin
                r_we <= 1'b0;
                r_re <= 1'b0;
                if (r_owner == OWN_I)
                    r_idata <= w_cap;
                else if (r_re)
                    r_dread <= w_cap;            // stores leave DataRead untouched
            end
        end
    end

    assign bus.memAddress       = r_addr;
    assign bus.memWData         = r_wdata;
    assign bus.memWE            = r_we;
    assign bus.memRE            = r_re;
    assign bus.InstructionData  = r_idata;
    assign bus.DataRead         = r_dread;
    assign bus.instructionReady = (r_state == RESP) && (r_owner == OWN_I);
    assign bus.dataReady        = (r_state == RESP) && (r_owner == OWN_D);

`ifdef BETA_ARB_TIMEOUT_EN
    logic w_in_grant, w_expire, r_buserr;

    assign w_in_grant = (r_state == GRANT_I) || (r_state == GRANT_D);
    // An ack in the expiry cycle still counts as a normal completion.
    assign w_timeout  = w_expire && !bus.memAck;

    beta_arb_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wd (
        .clk      (clk),
        .rst      (rst),
        .i_run    (w_in_grant),
        .o_expire (w_expire)
    );

    // busErr rides along with the ready pulse of a timed-out access.
    always_ff @(posedge clk) begin
        if (!rst)
            r_buserr <= 1'b0;
        else if (w_done)
            r_buserr <= w_timeout;
        else if (r_state == RESP)
            r_buserr <= 1'b0;
    end

    assign bus.busErr = r_buserr;
`else
    assign w_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_beta_mem_arbiter.sv
// Directed bench for beta_mem_arbiter with a behavioural memory, a grant log
// and a completion scoreboard. Timeout checks build with BETA_ARB_TIMEOUT_EN.
module tb_beta_mem_arbiter;

    typedef struct {
        bit          is_d;
        logic [31:0] data;
        bit          err;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic        re;
        logic [31:0] wdata;
    } gnt_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    beta_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    beta_mem_arbiter #(
        .ADDR_W(32), .DATA_W(32), .MAX_DATA_STREAK(4)
`ifdef BETA_ARB_TIMEOUT_EN
        , .TIMEOUT_CYCLES(8)
`endif
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int   n_assert = 0;
    int   n_fail   = 0;
    int   n_ready  = 0;
    exp_t sb_q[$];
    gnt_t grant_q[$];

    bit   mem_en    = 1'b1;
    bit   force_ack = 1'b0;
    int   mem_lat   = 1;
    int   mem_cnt   = 0;
    bit   prev_strb = 1'b0;

    function automatic logic [31:0] rdata_of(logic [31:0] a);
        if (a == 32'h100) return 32'hDEADBEEF;
        return {a[15:0], ~a[15:0]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Memory model and grant log, sampled/driven on the falling edge.
    always @(negedge clk) begin
        bit strb, ack_now;
        strb = bus.memRE || bus.memWE;
        if (strb && !prev_strb)
            grant_q.push_back('{bus.memAddress, bus.memWE, bus.memRE, bus.memWData});
        prev_strb = strb;
        if (mem_en && strb) mem_cnt++;
        else mem_cnt = 0;
        ack_now      = mem_en && strb && (mem_cnt == mem_lat);
        bus.memAck   = ack_now || force_ack;
        bus.memRData = bus.memAck ? rdata_of(bus.memAddress) : 32'h0;
    end

    // Completion monitor: pop the scoreboard on every ready pulse.
    always @(negedge clk) begin
        if (bus.instructionReady || bus.dataReady) begin
            n_ready++;
            chk("one_ready", {31'b0, bus.instructionReady & bus.dataReady}, 0);
            chk("sb_nonempty", {31'b0, sb_q.size() != 0}, 1);
            if (sb_q.size() != 0) begin
                exp_t e;
                e = sb_q.pop_front();
                chk("ready_owner", {31'b0, bus.dataReady}, {31'b0, e.is_d});
                chk("ready_data", e.is_d ? bus.DataRead : bus.InstructionData, e.data);
`ifdef BETA_ARB_TIMEOUT_EN
                chk("bus_err", {31'b0, bus.busErr}, {31'b0, e.err});
`endif
            end
        end
    end

    task automatic wait_rdy(input bit is_d, input string tag, output int cycles);
        bit ok;
        ok = 1'b0;
        cycles = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            cycles++;
            if (is_d ? bus.dataReady : bus.instructionReady) begin
                ok = 1'b1;
                break;
            end
        end
        chk({tag, "_seen"}, {31'b0, ok}, 1);
    endtask

    task automatic wait_any(input string tag);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (bus.dataReady || bus.instructionReady) begin
                ok = 1'b1;
                break;
            end
        end
        chk({tag, "_seen"}, {31'b0, ok}, 1);
    endtask

    task automatic chk_grant(input string tag, input logic [31:0] addr,
                             input logic we, input logic re, input logic [31:0] wd);
        chk({tag, "_logged"}, {31'b0, grant_q.size() != 0}, 1);
        if (grant_q.size() != 0) begin
            gnt_t g;
            g = grant_q.pop_front();
            chk({tag, "_addr"}, g.addr, addr);
            chk({tag, "_we"}, {31'b0, g.we}, {31'b0, we});
            chk({tag, "_re"}, {31'b0, g.re}, {31'b0, re});
            if (we) chk({tag, "_wdata"}, g.wdata, wd);
        end
    endtask

    initial begin
        int          cyc, saved;
        logic [31:0] last_dread;
        bit          ok;

        bus.InstructionAddress = '0; bus.iReq = 1'b0;
        bus.DataAddress = '0; bus.DataWrite = '0;
        bus.WriteEnable = 1'b0; bus.ReadEnable = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_memRE", {31'b0, bus.memRE}, 0);
        chk("rst_memWE", {31'b0, bus.memWE}, 0);
        chk("rst_memAddress", bus.memAddress, 0);
        chk("rst_irdy", {31'b0, bus.instructionReady}, 0);
        chk("rst_drdy", {31'b0, bus.dataReady}, 0);
        chk("rst_idata", bus.InstructionData, 0);
        chk("rst_dread", bus.DataRead, 0);
        rst = 1'b1;

        // Single fetch, 1-cycle memory
        sb_q.push_back('{1'b0, 32'hDEADBEEF, 1'b0});
        bus.InstructionAddress = 32'h100; bus.iReq = 1'b1;
        wait_rdy(1'b0, "t1", cyc);
        bus.iReq = 1'b0;
        chk("t1_latency", cyc, 2);
        chk_grant("t1_gnt", 32'h100, 1'b0, 1'b1, 32'h0);

        // Simultaneous fetch and load: data first
        mem_lat = 3;
        sb_q.push_back('{1'b1, rdata_of(32'h200), 1'b0});
        sb_q.push_back('{1'b0, rdata_of(32'h40), 1'b0});
        bus.InstructionAddress = 32'h40; bus.iReq = 1'b1;
        bus.DataAddress = 32'h200; bus.ReadEnable = 1'b1;
        wait_rdy(1'b1, "t2d", cyc);
        bus.ReadEnable = 1'b0;
        wait_rdy(1'b0, "t2i", cyc);
        bus.iReq = 1'b0;
        chk_grant("t2_gnt0", 32'h200, 1'b0, 1'b1, 32'h0);
        chk_grant("t2_gnt1", 32'h40, 1'b0, 1'b1, 32'h0);
        mem_lat = 1;

        // Data streak limit: D,D,D,D,I repeated
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < 4; k++) sb_q.push_back('{1'b1, rdata_of(32'h300), 1'b0});
            sb_q.push_back('{1'b0, rdata_of(32'h44), 1'b0});
        end
        last_dread = rdata_of(32'h300);
        bus.InstructionAddress = 32'h44; bus.iReq = 1'b1;
        bus.DataAddress = 32'h300; bus.ReadEnable = 1'b1;
        for (int k = 0; k < 10; k++) wait_any("t3");
        bus.iReq = 1'b0; bus.ReadEnable = 1'b0;
        repeat (4) @(negedge clk);
        chk("t3_grant_count", grant_q.size(), 10);
        for (int k = 0; k < 10; k++)
            chk_grant("t3_gnt", (k % 5 == 4) ? 32'h44 : 32'h300, 1'b0, 1'b1, 32'h0);

        // Write and read both set: write only, DataRead holds
        sb_q.push_back('{1'b1, last_dread, 1'b0});
        bus.DataAddress = 32'h80; bus.DataWrite = 32'h12345678;
        bus.WriteEnable = 1'b1; bus.ReadEnable = 1'b1;
        wait_rdy(1'b1, "t4", cyc);
        bus.WriteEnable = 1'b0; bus.ReadEnable = 1'b0;
        chk_grant("t4_gnt", 32'h80, 1'b1, 1'b0, 32'h12345678);

        // Reset during GRANT_D: access dropped, late ack ignored
        mem_en = 1'b0;
        bus.DataAddress = 32'h500; bus.ReadEnable = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.memRE) begin ok = 1'b1; break; end
        end
        chk("t5_granted", {31'b0, ok}, 1);
        saved = n_ready;
        rst = 1'b0; bus.ReadEnable = 1'b0;
        @(negedge clk);
        chk("t5_memRE", {31'b0, bus.memRE}, 0);
        chk("t5_drdy", {31'b0, bus.dataReady}, 0);
        rst = 1'b1; force_ack = 1'b1;
        repeat (2) @(negedge clk);
        force_ack = 1'b0;
        repeat (3) @(negedge clk);
        chk("t5_no_ready", n_ready, saved);
        chk("t5_no_strobe", {31'b0, bus.memRE | bus.memWE}, 0);
        chk_grant("t5_gnt", 32'h500, 1'b0, 1'b1, 32'h0);
        mem_en = 1'b1;
        sb_q.push_back('{1'b1, rdata_of(32'h504), 1'b0});
        bus.DataAddress = 32'h504; bus.ReadEnable = 1'b1;
        wait_rdy(1'b1, "t5_recover", cyc);
        bus.ReadEnable = 1'b0;
        chk_grant("t5_gnt2", 32'h504, 1'b0, 1'b1, 32'h0);

`ifdef BETA_ARB_TIMEOUT_EN
        // Timeout without memAck
        mem_en = 1'b0;
        sb_q.push_back('{1'b0, 32'h0, 1'b1});
        bus.InstructionAddress = 32'h600; bus.iReq = 1'b1;
        cyc = 0; ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.memRE) cyc++;
            if (bus.instructionReady) begin ok = 1'b1; break; end
        end
        bus.iReq = 1'b0;
        chk("t6_ready_seen", {31'b0, ok}, 1);
        chk("t6_grant_cycles", cyc, 8);
        chk_grant("t6_gnt", 32'h600, 1'b0, 1'b1, 32'h0);
        mem_en = 1'b1;
        sb_q.push_back('{1'b0, rdata_of(32'h604), 1'b0});
        bus.InstructionAddress = 32'h604; bus.iReq = 1'b1;
        wait_rdy(1'b0, "t6_next", cyc);
        bus.iReq = 1'b0;
        chk_grant("t6_gnt2", 32'h604, 1'b0, 1'b1, 32'h0);
`endif

        repeat (3) @(negedge clk);
        chk("sb_drained", sb_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
